// File: rtl/breg_pkg.sv
// Shared constants and types for the register-bank write path.
package breg_pkg;

   localparam int DATA_W = 32;             // bank word width
   localparam int ADDR_W = 5;              // register address width
   localparam int NREG   = 32;             // 2**ADDR_W registers

   localparam logic [ADDR_W-1:0] REG_ZERO = '0;   // $zero, never written

   // Producer identity; used as the round-robin "last granted" pointer.
   typedef enum logic {
      PROD_A = 1'b0,                       // ALU result
      PROD_B = 1'b1                        // memory-load result
   } prod_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. req[0]/gnt[0] is producer A,
// req[1]/gnt[1] is producer B. A lone requester is always granted; on a
// tie the requester that did not win last time gets the grant.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   import breg_pkg::*;

   prod_e last;

   // Grant is purely a function of req and the last-grant pointer.
   always_comb begin
      gnt = 2'b00;
      unique case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (last == PROD_A) ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
   end

   // Pointer follows every grant; reset to B so A wins the first tie.
   always_ff @(posedge clk) begin
      if (rst)         last <= PROD_B;
      else if (gnt[0]) last <= PROD_A;
      else if (gnt[1]) last <= PROD_B;
   end

endmodule

// File: rtl/breg_write_sched.sv
// Write-port scheduler and scoreboard for the 32x32 register bank.
// Producers A (ALU) and B (load) share the bank's single write port via a
// round-robin arbiter; the winner is registered onto AW/Di/RegWrite. A busy
// mask tracks destinations claimed by decode whose value has not yet been
// written, so decode can stall dependent reads.
module breg_write_sched #(
   parameter int DATA_W = breg_pkg::DATA_W,
   parameter int ADDR_W = breg_pkg::ADDR_W,
   parameter int NREG   = breg_pkg::NREG
) (
   input  logic              clk,
   input  logic              rst,
   // decode: destination claim
   input  logic              reserve_valid,
   input  logic [ADDR_W-1:0] reserve_addr,
   output logic              reserve_ready,
   // decode: source hazard check
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   output logic              stall,
   // producer A (ALU)
   input  logic              a_valid,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_data,
   output logic              a_ready,
   // producer B (load)
   input  logic              b_valid,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_data,
   output logic              b_ready,
   // bank write port
   output logic [ADDR_W-1:0] AW,
   output logic [DATA_W-1:0] Di,
   output logic              RegWrite,
   // status
   output logic [NREG-1:0]   busy_mask,
   output logic              err
);

   import breg_pkg::*;

   localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;

   logic [NREG-1:0]   busy;
   logic [NREG-1:0]   busy_nxt;
   logic [1:0]        gnt;
   logic              commit;
   logic [ADDR_W-1:0] c_addr;
   logic [DATA_W-1:0] c_data;
   logic              c_nz;
   logic              claim;
   logic              c_unowned;

   // ---------------------------------------------------------------------
   // Arbitration
   // ---------------------------------------------------------------------
   rr_arb2 u_arb (
      .clk (clk),
      .rst (rst),
      .req ({b_valid, a_valid}),
      .gnt (gnt)
   );

   assign a_ready = gnt[0];
   assign b_ready = gnt[1];

   // Winning producer's write, selected combinationally in the grant cycle.
   always_comb begin
      commit = |gnt;
      c_addr = gnt[1] ? b_addr : a_addr;
      c_data = gnt[1] ? b_data : a_data;
   end

   assign c_nz      = (c_addr != ZERO_ADDR);
   // A nonzero write nobody reserved is a protocol violation.
   assign c_unowned = commit & c_nz & ~busy[c_addr];

   // ---------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------
   // While rst is held the combinational outputs already show the
   // post-reset (all idle) scoreboard rather than the stale one.
   assign reserve_ready = rst | ~busy[reserve_addr];
   assign stall         = ~rst & (busy[ra1] | busy[ra2]);

   // busy[0] is never set, so claims of $zero are ready and ignored here.
   assign claim = reserve_valid & ~busy[reserve_addr] & (reserve_addr != REG_ZERO);

   // Clear on commit first, then apply the claim: a same-edge reserve of
   // the register being written belongs to a new producer and must win.
   always_comb begin
      busy_nxt = busy;
      if (commit) busy_nxt[c_addr] = 1'b0;
      if (claim)  busy_nxt[reserve_addr] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   // Scoreboard state; reset drops every outstanding reservation.
   always_ff @(posedge clk) begin
      if (rst) busy <= '0;
      else     busy <= busy_nxt;
   end

   assign busy_mask = busy;

   // ---------------------------------------------------------------------
   // Output register stage to the bank
   // ---------------------------------------------------------------------
   // Capture the granted write; AW/Di hold when idle, RegWrite pulses once
   // per grant and stays low for writes to $zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         AW       <= '0;
         Di       <= '0;
         RegWrite <= 1'b0;
      end else if (commit) begin
         AW       <= c_addr;
         Di       <= c_data;
         RegWrite <= c_nz;
      end else begin
         RegWrite <= 1'b0;
      end
   end

   // Sticky protocol error; only reset clears it.
   always_ff @(posedge clk) begin
      if (rst)            err <= 1'b0;
      else if (c_unowned) err <= 1'b1;
   end

endmodule

// File: tb/tb_breg_write_sched.sv
// Bench for breg_write_sched: a table of directed cycles covering the
// scenario list, followed by randomized traffic against a reference model.
module tb_breg_write_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        reserve_valid;
   logic [4:0]  reserve_addr;
   logic        reserve_ready;
   logic [4:0]  ra1, ra2;
   logic        stall;
   logic        a_valid, b_valid;
   logic [4:0]  a_addr, b_addr;
   logic [31:0] a_data, b_data;
   logic        a_ready, b_ready;
   logic [4:0]  AW;
   logic [31:0] Di;
   logic        RegWrite;
   logic [31:0] busy_mask;
   logic        err;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   breg_write_sched dut (
      .clk           (clk),
      .rst           (rst),
      .reserve_valid (reserve_valid),
      .reserve_addr  (reserve_addr),
      .reserve_ready (reserve_ready),
      .ra1           (ra1),
      .ra2           (ra2),
      .stall         (stall),
      .a_valid       (a_valid),
      .a_addr        (a_addr),
      .a_data        (a_data),
      .a_ready       (a_ready),
      .b_valid       (b_valid),
      .b_addr        (b_addr),
      .b_data        (b_data),
      .b_ready       (b_ready),
      .AW            (AW),
      .Di            (Di),
      .RegWrite      (RegWrite),
      .busy_mask     (busy_mask),
      .err           (err)
   );

   // One directed cycle: inputs, combinational expectations in that cycle,
   // registered expectations after the following edge.
   typedef struct {
      logic        rst;
      logic        rv;
      logic [4:0]  raddr;
      logic        av;
      logic [4:0]  aaddr;
      logic [31:0] adata;
      logic        bv;
      logic [4:0]  baddr;
      logic [31:0] bdata;
      logic [4:0]  ra1;
      logic [4:0]  ra2;
      logic        e_rr;
      logic        e_stall;
      logic        e_ar;
      logic        e_br;
      logic        e_rw;
      logic [4:0]  e_aw;
      logic [31:0] e_di;
      logic [31:0] e_busy;
      logic        e_err;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h, want %0h", nm, $time, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic rv, input logic [4:0] rad,
                        input logic av, input logic [4:0] aad, input logic [31:0] ad,
                        input logic bv, input logic [4:0] bad, input logic [31:0] bd,
                        input logic [4:0] s1, input logic [4:0] s2);
      rst = r; reserve_valid = rv; reserve_addr = rad;
      a_valid = av; a_addr = aad; a_data = ad;
      b_valid = bv; b_addr = bad; b_data = bd;
      ra1 = s1; ra2 = s2;
   endtask

   vec_t vt[24];

   // Reference model state (spec-level view of the scoreboard and port)
   bit [31:0] m_busy;
   int        m_last;       // 0 = A granted last, 1 = B
   bit [4:0]  m_aw;
   bit [31:0] m_di;
   bit        m_rw, m_err;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      //        rst rv ra   av aa adata          bv ba bdata          r1 r2  rr st ar br  rw aw di             busy          err
      vt[0]  = '{0, 1, 5,  0, 0, 32'h0,        0, 0, 32'h0,        5, 0,  1, 0, 0, 0,  0, 0, 32'h0,        32'h20,       0};
      vt[1]  = '{0, 0, 0,  1, 5, 32'hDEADBEEF, 0, 0, 32'h0,        5, 0,  1, 1, 1, 0,  1, 5, 32'hDEADBEEF, 32'h0,        0};
      vt[2]  = '{0, 0, 0,  0, 0, 32'h0,        0, 0, 32'h0,        5, 0,  1, 0, 0, 0,  0, 5, 32'hDEADBEEF, 32'h0,        0};
      vt[3]  = '{1, 0, 0,  0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  1, 0, 0, 0,  0, 0, 32'h0,        32'h0,        0};
      vt[4]  = '{0, 1, 3,  0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  1, 0, 0, 0,  0, 0, 32'h0,        32'h8,        0};
      vt[5]  = '{0, 1, 4,  0, 0, 32'h0,        0, 0, 32'h0,        3, 0,  1, 1, 0, 0,  0, 0, 32'h0,        32'h18,       0};
      vt[6]  = '{0, 0, 0,  1, 3, 32'h11,       1, 4, 32'h22,       3, 4,  1, 1, 1, 0,  1, 3, 32'h11,       32'h10,       0};
      vt[7]  = '{0, 0, 0,  0, 0, 32'h0,        1, 4, 32'h22,       3, 4,  1, 1, 0, 1,  1, 4, 32'h22,       32'h0,        0};
      vt[8]  = '{0, 0, 0,  0, 0, 32'h0,        0, 0, 32'h0,        3, 4,  1, 0, 0, 0,  0, 4, 32'h22,       32'h0,        0};
      // contention on $zero: alternate A,B,... with RegWrite low throughout
      vt[9]  = '{0, 1, 0,  1, 0, 32'hA0,       1, 0, 32'hB0,       0, 0,  1, 0, 1, 0,  0, 0, 32'hA0,       32'h0,        0};
      vt[10] = '{0, 0, 0,  1, 0, 32'hA1,       1, 0, 32'hB0,       0, 0,  1, 0, 0, 1,  0, 0, 32'hB0,       32'h0,        0};
      vt[11] = '{0, 0, 0,  1, 0, 32'hA1,       1, 0, 32'hB1,       0, 0,  1, 0, 1, 0,  0, 0, 32'hA1,       32'h0,        0};
      vt[12] = '{0, 0, 0,  1, 0, 32'hA2,       1, 0, 32'hB1,       0, 0,  1, 0, 0, 1,  0, 0, 32'hB1,       32'h0,        0};
      vt[13] = '{0, 0, 0,  1, 0, 32'hA2,       1, 0, 32'hB2,       0, 0,  1, 0, 1, 0,  0, 0, 32'hA2,       32'h0,        0};
      vt[14] = '{0, 0, 0,  1, 0, 32'hA3,       1, 0, 32'hB2,       0, 0,  1, 0, 0, 1,  0, 0, 32'hB2,       32'h0,        0};
      // r7 double reserve, commit while reserve held, then unowned r9 commit
      vt[15] = '{0, 1, 7,  0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  1, 0, 0, 0,  0, 0, 32'hB2,       32'h80,       0};
      vt[16] = '{0, 1, 7,  0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  0, 0, 0, 0,  0, 0, 32'hB2,       32'h80,       0};
      vt[17] = '{0, 1, 7,  1, 7, 32'h77,       0, 0, 32'h0,        7, 0,  0, 1, 1, 0,  1, 7, 32'h77,       32'h0,        0};
      vt[18] = '{0, 1, 7,  0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  1, 0, 0, 0,  0, 7, 32'h77,       32'h80,       0};
      vt[19] = '{0, 1, 9,  1, 9, 32'h99,       0, 0, 32'h0,        0, 0,  1, 0, 1, 0,  1, 9, 32'h99,       32'h280,      1};
      vt[20] = '{0, 0, 0,  0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  1, 0, 0, 0,  0, 9, 32'h99,       32'h280,      1};
      vt[21] = '{0, 0, 0,  0, 0, 32'h0,        1, 7, 32'h70,       0, 0,  1, 0, 0, 1,  1, 7, 32'h70,       32'h200,      1};
      vt[22] = '{0, 1, 12, 1, 9, 32'h90,       0, 0, 32'h0,        0, 0,  1, 0, 1, 0,  1, 9, 32'h90,       32'h1000,     1};
      // reset right after a grant, with r12 busy and a live request
      vt[23] = '{1, 1, 12, 1, 1, 32'h55,       0, 0, 32'h0,        12, 0, 1, 0, 1, 0,  0, 0, 32'h0,        32'h0,        0};

      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("reset RegWrite", RegWrite, 0);
      chk("reset AW", AW, 0);
      chk("reset Di", Di, 0);
      chk("reset busy_mask", busy_mask, 0);
      chk("reset err", err, 0);
      chk("reset reserve_ready", reserve_ready, 1);
      chk("reset stall", stall, 0);

      for (int i = 0; i < 24; i++) begin
         drive(vt[i].rst, vt[i].rv, vt[i].raddr, vt[i].av, vt[i].aaddr, vt[i].adata,
               vt[i].bv, vt[i].baddr, vt[i].bdata, vt[i].ra1, vt[i].ra2);
         #4;
         chk($sformatf("v%0d reserve_ready", i), reserve_ready, vt[i].e_rr);
         chk($sformatf("v%0d stall", i), stall, vt[i].e_stall);
         chk($sformatf("v%0d a_ready", i), a_ready, vt[i].e_ar);
         chk($sformatf("v%0d b_ready", i), b_ready, vt[i].e_br);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d RegWrite", i), RegWrite, vt[i].e_rw);
         chk($sformatf("v%0d AW", i), AW, vt[i].e_aw);
         chk($sformatf("v%0d Di", i), Di, vt[i].e_di);
         chk($sformatf("v%0d busy_mask", i), busy_mask, vt[i].e_busy);
         chk($sformatf("v%0d err", i), err, vt[i].e_err);
      end

      // ---------------- randomized traffic vs. reference model ----------
      // The last vector reset the DUT, so the model starts idle.
      m_busy = '0; m_last = 1; m_aw = '0; m_di = '0; m_rw = 0; m_err = 0;
      begin
         bit        a_hold, b_hold;
         logic      r, rv, av, bv;
         logic [4:0] rad, aad, bad, s1, s2;
         logic [31:0] ad, bd;
         int        g;
         bit        accept;
         a_hold = 0; b_hold = 0;
         av = 0; bv = 0; aad = '0; bad = '0; ad = '0; bd = '0;
         for (int c = 0; c < 600; c++) begin
            if (!a_hold) begin
               av = 1'($urandom_range(1, 0));
               aad = 5'($urandom_range(7, 0));
               ad = $urandom;
            end
            if (!b_hold) begin
               bv = 1'($urandom_range(1, 0));
               bad = 5'($urandom_range(7, 0));
               bd = $urandom;
            end
            rv  = 1'($urandom_range(1, 0));
            rad = 5'($urandom_range(7, 0));
            s1  = 5'($urandom_range(7, 0));
            s2  = 5'($urandom_range(7, 0));
            r   = ($urandom_range(79, 0) == 0);
            drive(r, rv, rad, av, aad, ad, bv, bad, bd, s1, s2);
            #4;
            // model: who should win, and what decode should see
            if (av && bv)  g = (m_last == 0) ? 2 : 1;
            else if (av)   g = 1;
            else if (bv)   g = 2;
            else           g = 0;
            chk("rnd reserve_ready", reserve_ready, (r || rad == 0 || !m_busy[rad]) ? 1 : 0);
            chk("rnd stall", stall, (!r && (m_busy[s1] || m_busy[s2])) ? 1 : 0);
            chk("rnd a_ready", a_ready, (g == 1) ? 1 : 0);
            chk("rnd b_ready", b_ready, (g == 2) ? 1 : 0);
            @(posedge clk);
            if (r) begin
               m_busy = '0; m_last = 1; m_aw = '0; m_di = '0; m_rw = 0; m_err = 0;
            end else begin
               accept = rv && rad != 0 && !m_busy[rad];
               if (g != 0) begin
                  logic [4:0]  wa;
                  logic [31:0] wd;
                  wa = (g == 1) ? aad : bad;
                  wd = (g == 1) ? ad : bd;
                  if (wa != 0 && !m_busy[wa]) m_err = 1;
                  m_aw = wa;
                  m_di = wd;
                  m_rw = (wa != 0);
                  m_busy[wa] = 1'b0;
                  m_last = g - 1;
               end else begin
                  m_rw = 0;
               end
               if (accept) m_busy[rad] = 1'b1;
            end
            #1;
            chk("rnd RegWrite", RegWrite, m_rw);
            chk("rnd AW", AW, m_aw);
            chk("rnd Di", Di, m_di);
            chk("rnd busy_mask", busy_mask, m_busy);
            chk("rnd err", err, m_err);
            a_hold = av && (g != 1);
            b_hold = bv && (g != 2);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
